apb_master_ctrl: RTL and testbench

- Parametrised, registered APB master for the AHB-APB bridge. Replaces the pass-through APB stage with a real SETUP/ACCESS state machine.
- Accepts one transfer request at a time from the bridge FSM. Decodes the target slave from the upper address bits and drives the APB bus.
- Supports PREADY wait states, PSLVERR and a wait-state timeout. Returns read data and error status on a one-cycle response strobe.

---
 rtl/apb_master_ctrl.sv | 115 +++++++++++
 tb/tb_apb_master_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// Registered APB master: takes one request at a time from the bridge FSM and runs
// a SETUP/ACCESS transfer with PREADY wait states, PSLVERR and wait-state timeout.
module apb_master_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SLAVES     = 4,
    parameter int SEL_BITS   = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] Paddr,
    output logic                  Pwrite,
    output logic                  Penable,
    output logic [DATA_WIDTH-1:0] Pwdata,
    output logic [SLAVES-1:0]     Pselx,
    input  logic [DATA_WIDTH-1:0] Prdata,
    input  logic                  Pready,
    input  logic                  Pslverr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [SEL_BITS-1:0] req_idx;
    logic              idx_ok;
    logic              timeout_hit;

    function automatic logic [SLAVES-1:0] onehot(input logic [SEL_BITS-1:0] idx);
        logic [SLAVES-1:0] sel;
        sel = '0;
        for (int s = 0; s < SLAVES; s++) begin
            sel[s] = (32'(idx) == 32'(s));
        end
        return sel;
    endfunction

    assign req_ready   = (state == IDLE);
    assign req_idx     = req_addr[ADDR_WIDTH-1 -: SEL_BITS];
    assign idx_ok      = (32'(req_idx) < 32'(SLAVES));
    // With TIMEOUT == 0 the counter simply wraps and never aborts.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= IDLE;
            cnt       <= '0;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (idx_ok) begin
                            Paddr  <= req_addr;
                            Pwrite <= req_write;
                            Pwdata <= req_wdata;
                            Pselx  <= onehot(req_idx);
                            cnt    <= '0;
                            state  <= SETUP;
                        end else begin
                            // Unmapped slave: answer with an error, bus stays quiet.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    Penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (Pready) begin
                        Pselx     <= '0;
                        Penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= Pslverr;
                        rsp_rdata <= Pwrite ? '0 : Prdata;
                        state     <= IDLE;
                    end else if (timeout_hit) begin
                        Pselx     <= '0;
                        Penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: main instance (4 slaves, timeout 16) and a
// 3-slave instance for the unmapped-index path.
module tb_apb_master_ctrl;

    logic        Hclk;
    logic        Hresetn;
    logic        req_valid, req_valid3;
    logic        req_ready, req_ready3;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_valid3;
    logic [31:0] rsp_rdata, rsp_rdata3;
    logic        rsp_err, rsp_err3;
    logic [31:0] Paddr, Paddr3;
    logic        Pwrite, Pwrite3;
    logic        Penable, Penable3;
    logic [31:0] Pwdata, Pwdata3;
    logic [3:0]  Pselx;
    logic [2:0]  Pselx3;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    int checks = 0;
    int errors = 0;

    apb_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVES(4), .SEL_BITS(2), .TIMEOUT(16)) u_dut (
        .Hclk(Hclk), .Hresetn(Hresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Paddr(Paddr), .Pwrite(Pwrite), .Penable(Penable), .Pwdata(Pwdata), .Pselx(Pselx),
        .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    apb_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVES(3), .SEL_BITS(2), .TIMEOUT(4)) u_dut3 (
        .Hclk(Hclk), .Hresetn(Hresetn),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .Paddr(Paddr3), .Pwrite(Pwrite3), .Penable(Penable3), .Pwdata(Pwdata3), .Pselx(Pselx3),
        .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    initial begin
        Hresetn    = 1'b0;
        req_valid  = 1'b0;
        req_valid3 = 1'b0;
        req_addr   = '0;
        req_write  = 1'b0;
        req_wdata  = '0;
        Prdata     = '0;
        Pready     = 1'b1;
        Pslverr    = 1'b0;

        // Reset values
        #1;
        chk("rst_pselx", Pselx, 4'b0000);
        chk("rst_penable", Penable, 1'b0);
        chk("rst_paddr", Paddr, 32'h0);
        chk("rst_pwdata", Pwdata, 32'h0);
        chk("rst_pwrite", Pwrite, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        tick();
        Hresetn = 1'b1;
        tick();
        chk("rst_req_ready", req_ready, 1'b1);

        // Write, no wait states
        req_valid = 1'b1; req_addr = 32'h4000_0010; req_write = 1'b1; req_wdata = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_write = 1'b0;
        chk("wr_setup_pselx", Pselx, 4'b0010);
        chk("wr_setup_penable", Penable, 1'b0);
        chk("wr_setup_paddr", Paddr, 32'h4000_0010);
        chk("wr_setup_pwrite", Pwrite, 1'b1);
        chk("wr_setup_pwdata", Pwdata, 32'hDEAD_BEEF);
        chk("wr_setup_req_ready", req_ready, 1'b0);
        tick();
        chk("wr_access_penable", Penable, 1'b1);
        chk("wr_access_pselx", Pselx, 4'b0010);
        chk("wr_access_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_rsp_err", rsp_err, 1'b0);
        chk("wr_rsp_rdata", rsp_rdata, 32'h0);
        chk("wr_done_pselx", Pselx, 4'b0000);
        chk("wr_done_penable", Penable, 1'b0);
        chk("wr_done_paddr_hold", Paddr, 32'h4000_0010);
        chk("wr_done_req_ready", req_ready, 1'b1);
        tick();
        chk("wr_rsp_one_cycle", rsp_valid, 1'b0);

        // Read with three wait states
        Pready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8000_0004; req_write = 1'b0; req_wdata = 32'h5555_AAAA;
        tick();
        req_valid = 1'b0; req_addr = 32'h0;
        chk("rd_setup_pselx", Pselx, 4'b0100);
        chk("rd_setup_pwrite", Pwrite, 1'b0);
        chk("rd_setup_pwdata", Pwdata, 32'h5555_AAAA);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("rd_wait_penable", Penable, 1'b1);
            chk("rd_wait_pselx", Pselx, 4'b0100);
            chk("rd_wait_paddr", Paddr, 32'h8000_0004);
            chk("rd_wait_rsp_valid", rsp_valid, 1'b0);
        end
        tick();
        chk("rd_last_access_penable", Penable, 1'b1);
        Pready = 1'b1; Prdata = 32'h1234_5678;
        tick();
        Prdata = 32'hFFFF_0000;
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("rd_rsp_err", rsp_err, 1'b0);
        chk("rd_done_pselx", Pselx, 4'b0000);
        tick();
        chk("rd_rsp_one_cycle", rsp_valid, 1'b0);
        chk("rd_rdata_not_resampled", rsp_rdata, 32'h1234_5678);

        // Read with slave error, back-to-back request in the response cycle
        Pslverr = 1'b1; Prdata = 32'h1234_5678;
        req_valid = 1'b1; req_addr = 32'h0000_0008; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("err_setup_pselx", Pselx, 4'b0001);
        tick();
        tick();
        chk("err_rsp_valid", rsp_valid, 1'b1);
        chk("err_rsp_err", rsp_err, 1'b1);
        chk("err_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("err_req_ready", req_ready, 1'b1);
        Pslverr = 1'b0;
        req_valid = 1'b1; req_addr = 32'hC000_0020; req_write = 1'b1; req_wdata = 32'h0BAD_F00D;
        tick();
        req_valid = 1'b0;
        chk("b2b_setup_pselx", Pselx, 4'b1000);
        chk("b2b_setup_paddr", Paddr, 32'hC000_0020);
        chk("b2b_rsp_valid_low", rsp_valid, 1'b0);
        tick();
        tick();
        chk("b2b_rsp_valid", rsp_valid, 1'b1);
        chk("b2b_rsp_err", rsp_err, 1'b0);
        chk("b2b_rsp_rdata", rsp_rdata, 32'h0);
        tick();

        // Unmapped slave index on the 3-slave instance
        req_valid3 = 1'b1; req_addr = 32'hC000_0000; req_write = 1'b0;
        chk("dec_req_ready", req_ready3, 1'b1);
        tick();
        req_valid3 = 1'b0;
        chk("dec_rsp_valid", rsp_valid3, 1'b1);
        chk("dec_rsp_err", rsp_err3, 1'b1);
        chk("dec_rsp_rdata", rsp_rdata3, 32'h0);
        chk("dec_pselx", Pselx3, 3'b000);
        chk("dec_penable", Penable3, 1'b0);
        chk("dec_req_ready_idle", req_ready3, 1'b1);
        tick();
        chk("dec_rsp_one_cycle", rsp_valid3, 1'b0);
        chk("dec_pselx_after", Pselx3, 3'b000);

        // Wait-state timeout
        Pready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h4000_0000; req_write = 1'b1; req_wdata = 32'h0000_0001;
        tick();
        req_valid = 1'b0;
        tick();
        chk("to_access_1", Penable, 1'b1);
        for (int c = 2; c <= 16; c++) begin
            tick();
            chk("to_access_hold", Penable, 1'b1);
            chk("to_access_no_rsp", rsp_valid, 1'b0);
        end
        tick();
        chk("to_pselx", Pselx, 4'b0000);
        chk("to_penable", Penable, 1'b0);
        chk("to_rsp_valid", rsp_valid, 1'b1);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
        Pready = 1'b1; Prdata = 32'hAAAA_BBBB;
        tick();
        chk("to_late_rsp_valid", rsp_valid, 1'b0);
        chk("to_late_pselx", Pselx, 4'b0000);
        chk("to_late_req_ready", req_ready, 1'b1);

        // Reset pulsed during ACCESS
        Pready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8000_0040; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_access_penable", Penable, 1'b1);
        #2;
        Hresetn = 1'b0;
        #1;
        chk("mid_rst_pselx", Pselx, 4'b0000);
        chk("mid_rst_penable", Penable, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_paddr", Paddr, 32'h0);
        Pready = 1'b1;
        tick();
        Hresetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_rsp_valid", rsp_valid, 1'b0);
            chk("post_rst_pselx", Pselx, 4'b0000);
            chk("post_rst_req_ready", req_ready, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
